// File: rtl/ecc_rd_scrub_ctrl.sv
// ecc_rd_scrub_ctrl: realigns read beats with a fixed-latency SECDED decoder, classifies them,
// queues corrected beats for scrub write-back and keeps error counters plus a first-fatal log.
module ecc_rd_scrub_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEC_LAT     = 2,
  parameter int SCRUB_DEPTH = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [71:0]       rd_data,
  output logic [71:0]       dec_data,
  input  logic [63:0]       dec_q,
  input  logic              dec_err_corrected,
  input  logic              dec_err_detected,
  input  logic              dec_err_fatal,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [63:0]       out_data,
  output logic              out_poison,
  output logic              scrub_valid,
  output logic [ADDR_W-1:0] scrub_addr,
  output logic [63:0]       scrub_data,
  input  logic              scrub_ready,
  output logic              scrub_overflow,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  fatal_cnt,
  output logic              fatal_log_valid,
  output logic [ADDR_W-1:0] fatal_log_addr,
  input  logic              cnt_clr
);
  localparam int PW = $clog2(SCRUB_DEPTH);
  logic [DEC_LAT-1:0] pv;
  logic [ADDR_W-1:0]  pa [DEC_LAT];
  logic               sv, fatal, corr, out_corr;
  logic [PW:0]        wp, rp;
  logic [ADDR_W+63:0] mem [SCRUB_DEPTH];
  logic               empty, full, pop, push_req, push, drop;
  assign dec_data = rd_data;
  assign sv    = pv[DEC_LAT-1];
  assign fatal = sv & (dec_err_fatal | (dec_err_detected & ~dec_err_corrected));
  assign corr  = sv & dec_err_corrected & ~fatal;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pv <= '0;
      for (int i = 0; i < DEC_LAT; i++) pa[i] <= '0;
    end else begin
      pv[0] <= rd_valid;
      pa[0] <= rd_addr;
      for (int i = 1; i < DEC_LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      out_poison <= 1'b0;
      out_corr   <= 1'b0;
    end else begin
      out_valid  <= sv;
      out_addr   <= pa[DEC_LAT-1];
      out_data   <= dec_q;
      out_poison <= fatal;
      out_corr   <= corr;
    end
  // Scrub entries are pushed from the output register, so scrub_valid trails out_valid by one cycle.
  assign empty       = wp == rp;
  assign full        = (wp[PW-1:0] == rp[PW-1:0]) & (wp[PW] != rp[PW]);
  assign pop         = ~empty & scrub_ready;
  assign push_req    = out_valid & out_corr;
  assign push        = push_req & (~full | pop);
  assign drop        = push_req & full & ~pop;
  assign scrub_valid = ~empty;
  assign {scrub_addr, scrub_data} = mem[rp[PW-1:0]];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < SCRUB_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) mem[wp[PW-1:0]] <= {out_addr, out_data};
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      corr_cnt        <= '0;
      fatal_cnt       <= '0;
      fatal_log_valid <= 1'b0;
      fatal_log_addr  <= '0;
      scrub_overflow  <= 1'b0;
    end else if (cnt_clr) begin
      corr_cnt        <= '0;
      fatal_cnt       <= '0;
      fatal_log_valid <= 1'b0;
      fatal_log_addr  <= '0;
      scrub_overflow  <= 1'b0;
    end else begin
      if (corr && corr_cnt != '1) corr_cnt <= corr_cnt + 1'b1;
      if (fatal && fatal_cnt != '1) fatal_cnt <= fatal_cnt + 1'b1;
      if (fatal && !fatal_log_valid) begin
        fatal_log_valid <= 1'b1;
        fatal_log_addr  <= pa[DEC_LAT-1];
      end
      if (drop) scrub_overflow <= 1'b1;
    end
endmodule

// File: tb/tb_ecc_rd_scrub_ctrl.sv
// tb_ecc_rd_scrub_ctrl: table vectors, directed corner sequences and random traffic checked
// against a history/queue reference model; a stub decoder flips one tagged bit back.
module tb_ecc_rd_scrub_ctrl;
  localparam int AW = 32, D = 4, CW = 4, SAT = 15;
  logic          clock = 0, reset = 1;
  logic          rd_valid = 0, scrub_ready = 0, cnt_clr = 0;
  logic [AW-1:0] rd_addr = '0;
  logic [71:0]   rd_data = '0, dec_data;
  logic [63:0]   dec_q, out_data, scrub_data;
  logic          dec_err_corrected, dec_err_detected, dec_err_fatal;
  logic          out_valid, out_poison, scrub_valid, scrub_overflow, fatal_log_valid;
  logic [AW-1:0] out_addr, scrub_addr, fatal_log_addr;
  logic [CW-1:0] corr_cnt, fatal_cnt;
  int nvec = 0, nerr = 0;

  ecc_rd_scrub_ctrl #(.ADDR_W(AW), .DEC_LAT(2), .SCRUB_DEPTH(D), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .dec_data(dec_data), .dec_q(dec_q), .dec_err_corrected(dec_err_corrected),
    .dec_err_detected(dec_err_detected), .dec_err_fatal(dec_err_fatal),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data), .out_poison(out_poison),
    .scrub_valid(scrub_valid), .scrub_addr(scrub_addr), .scrub_data(scrub_data),
    .scrub_ready(scrub_ready), .scrub_overflow(scrub_overflow), .corr_cnt(corr_cnt),
    .fatal_cnt(fatal_cnt), .fatal_log_valid(fatal_log_valid), .fatal_log_addr(fatal_log_addr),
    .cnt_clr(cnt_clr));

  always #5 clock = ~clock;

  // Stub decoder: check byte = {flip index[4:0], fatal, detected, corrected}, two-cycle latency.
  logic [71:0] d1, d2;
  always @(posedge clock) begin
    d1 <= dec_data;
    d2 <= d1;
  end
  assign dec_err_corrected = d2[64];
  assign dec_err_detected  = d2[65];
  assign dec_err_fatal     = d2[66];
  assign dec_q = d2[63:0] ^ (d2[64] ? (64'd1 << d2[71:67]) : 64'd0);

  typedef struct {logic v; logic [AW-1:0] a; logic [71:0] w;} beat_t;
  beat_t         h [3];
  logic [95:0]   q [$];
  logic          m_ov, m_pois, m_corr, m_lv, m_ovf;
  logic [AW-1:0] m_addr, m_la;
  logic [63:0]   m_data;
  int            m_cc, m_fc;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) h[i] = '{1'b0, '0, '0};
    q.delete();
    {m_ov, m_pois, m_corr, m_lv, m_ovf} = '0;
    m_addr = '0; m_la = '0; m_data = '0; m_cc = 0; m_fc = 0;
  endtask

  task automatic model_edge();
    logic pop, full, c, d, f, fat, cor;
    beat_t b;
    full = q.size() == D;
    pop  = q.size() != 0 && scrub_ready;
    if (pop) void'(q.pop_front());
    if (m_ov && m_corr) begin
      if (!full || pop) q.push_back({m_addr, m_data});
      else m_ovf = 1;
    end
    h[2] = h[1]; h[1] = h[0]; h[0] = '{rd_valid, rd_addr, rd_data};
    b = h[2];
    c = b.w[64]; d = b.w[65]; f = b.w[66];
    fat = b.v && (f || (d && !c));
    cor = b.v && c && !fat;
    m_ov = b.v; m_pois = fat; m_corr = cor; m_addr = b.a;
    m_data = b.w[63:0] ^ (c ? (64'd1 << b.w[71:67]) : 64'd0);
    if (cnt_clr) begin
      m_cc = 0; m_fc = 0; m_lv = 0; m_la = '0; m_ovf = 0;
    end else begin
      if (cor && m_cc < SAT) m_cc++;
      if (fat && m_fc < SAT) m_fc++;
      if (fat && !m_lv) begin m_lv = 1; m_la = b.a; end
    end
  endtask

  task automatic chk(input string n, input logic [95:0] act, input logic [95:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("dec_data", dec_data, rd_data);
    chk("out_valid", out_valid, m_ov);
    chk("out_poison", out_poison, m_pois);
    if (m_ov) begin
      chk("out_addr", out_addr, m_addr);
      chk("out_data", out_data, m_data);
    end
    chk("scrub_valid", scrub_valid, q.size() != 0);
    if (q.size() != 0) chk("scrub_head", {scrub_addr, scrub_data}, q[0]);
    chk("scrub_overflow", scrub_overflow, m_ovf);
    chk("corr_cnt", corr_cnt, m_cc);
    chk("fatal_cnt", fatal_cnt, m_fc);
    chk("fatal_log_valid", fatal_log_valid, m_lv);
    chk("fatal_log_addr", fatal_log_addr, m_la);
  endtask

  task automatic cyc(input logic v, input logic [AW-1:0] a, input logic [71:0] w,
                     input logic rdy, input logic clr);
    rd_valid = v; rd_addr = a; rd_data = w; scrub_ready = rdy; cnt_clr = clr;
    @(posedge clock);
    model_edge();
    #1 compare_all();
  endtask

  function automatic logic [71:0] cw(input logic [63:0] orig, input logic [4:0] idx);
    return {idx, 3'b011, orig ^ (64'd1 << idx)};
  endfunction

  typedef struct {
    logic v; logic [AW-1:0] a; logic [71:0] w; logic rdy, clr;
    logic ov, pois, sv; int cc, fc;
  } vec_t;
  vec_t tbl [17];

  initial begin
    tbl[0]  = '{1, 32'h100, {8'h00, 64'h1111_0000_0000_0100}, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 32'h101, {8'h00, 64'h2222_0000_0000_0101}, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 32'h102, {8'h00, 64'h3333_0000_0000_0102}, 1, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{1, 32'h040, {8'h2B, 64'h0123_4567_89AB_CDCF}, 1, 0, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 32'h080, {8'h02, 64'hDEAD_BEEF_0000_0080}, 1, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{1, 32'h090, {8'h04, 64'hDEAD_BEEF_0000_0090}, 0, 0, 1, 0, 0, 1, 0};
    tbl[6]  = '{0, 32'h000, {8'h00, 64'h0},                   0, 0, 1, 1, 1, 1, 1};
    tbl[7]  = '{0, 32'h000, {8'h00, 64'h0},                   0, 0, 1, 1, 1, 1, 2};
    tbl[8]  = '{0, 32'h000, {8'h00, 64'h0},                   1, 0, 0, 0, 0, 1, 2};
    tbl[9]  = '{0, 32'h0F0, {8'h07, 64'hFFFF_FFFF_FFFF_FFFF}, 1, 0, 0, 0, 0, 1, 2};
    tbl[10] = '{0, 32'h000, {8'h00, 64'h0},                   1, 0, 0, 0, 0, 1, 2};
    tbl[11] = '{0, 32'h000, {8'h07, 64'h5},                   1, 0, 0, 0, 0, 1, 2};
    tbl[12] = '{1, 32'h044, {8'h2B, 64'h0000_0000_0000_0020}, 1, 0, 0, 0, 0, 1, 2};
    tbl[13] = '{0, 32'h000, {8'h00, 64'h0},                   1, 0, 0, 0, 0, 1, 2};
    tbl[14] = '{0, 32'h000, {8'h00, 64'h0},                   0, 1, 1, 0, 0, 0, 0};
    tbl[15] = '{0, 32'h000, {8'h00, 64'h0},                   1, 0, 0, 0, 1, 0, 0};
    tbl[16] = '{0, 32'h000, {8'h00, 64'h0},                   1, 0, 0, 0, 0, 0, 0};
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 0;

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].v, tbl[i].a, tbl[i].w, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d.out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d.out_poison", i), out_poison, tbl[i].pois);
      chk($sformatf("tbl%0d.scrub_valid", i), scrub_valid, tbl[i].sv);
      chk($sformatf("tbl%0d.corr_cnt", i), corr_cnt, tbl[i].cc);
      chk($sformatf("tbl%0d.fatal_cnt", i), fatal_cnt, tbl[i].fc);
      if (i == 5) chk("corrected_out_data", out_data, 64'h0123_4567_89AB_CDEF);
      if (i == 6) chk("scrub_entry", {scrub_addr, scrub_data}, {32'h40, 64'h0123_4567_89AB_CDEF});
      if (i == 8) chk("first_fatal_log", {fatal_log_valid, fatal_log_addr}, {1'b1, 32'h80});
    end

    // Five corrected beats into a depth-4 FIFO with no consumer: the fifth is dropped.
    for (int i = 0; i < 5; i++) cyc(1, 32'h200 + i, cw(64'hA000 + i, 5'(i)), 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    chk("ovf_set", scrub_overflow, 1'b1);
    chk("ovf_corr_cnt", corr_cnt, 5);
    chk("ovf_head", scrub_addr, 32'h200);
    // Push into a full FIFO during a pop cycle is accepted without overflow.
    cyc(0, 0, 0, 0, 1);
    cyc(1, 32'h300, cw(64'hBEEF, 5'd9), 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("full_pop_push_no_ovf", scrub_overflow, 1'b0);
    chk("full_pop_push_head", scrub_addr, 32'h201);
    repeat (6) cyc(0, 0, 0, 1, 0);

    // Counter saturation.
    for (int i = 0; i < 20; i++) cyc(1, 32'h400 + i, cw($urandom, 5'($urandom)), 1, 0);
    repeat (4) cyc(0, 0, 0, 1, 0);
    chk("corr_cnt_saturated", corr_cnt, SAT);

    // Asynchronous reset with three FIFO entries and two beats in flight.
    for (int i = 0; i < 3; i++) cyc(1, 32'h500 + i, cw(64'hC000 + i, 5'd1), 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(1, 32'h600, {8'h00, 64'h600}, 0, 0);
    cyc(1, 32'h601, {8'h00, 64'h601}, 0, 0);
    chk("pre_reset_fifo", scrub_valid, 1'b1);
    rd_valid = 0;
    #2 reset = 1;
    #1;
    chk("rst_outs", {out_valid, out_poison, scrub_valid, scrub_overflow, fatal_log_valid}, 0);
    chk("rst_addr_data", {out_addr, out_data}, 0);
    chk("rst_scrub", {scrub_addr, scrub_data}, 0);
    chk("rst_cnts", {corr_cnt, fatal_cnt, fatal_log_addr}, 0);
    model_reset();
    @(posedge clock);
    #1 reset = 0;
    cyc(1, 32'h777, {8'h00, 64'h777}, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("post_rst_no_stale", {out_valid, scrub_valid}, 0);
    cyc(0, 0, 0, 0, 0);
    chk("post_rst_latency", {out_valid, out_addr}, {1'b1, 32'h777});

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] ck;
      int r;
      r = $urandom_range(0, 7);
      ck[7:3] = 5'($urandom);
      ck[2:0] = r < 4 ? 3'b000 : r < 6 ? {2'b00, 1'b1} | {1'b0, 1'($urandom), 1'b0} :
                r == 6 ? 3'b010 : 3'($urandom);
      cyc($urandom_range(0, 3) != 0, $urandom, {ck, $urandom, $urandom},
          $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/ecc_rd_scrub_ctrl.md
Name: ecc_rd_scrub_ctrl

Overview:
Sequences the memory-controller read path through the fixed-latency 72/64 SECDED decoder (DEC_LAT = 2 cycles). Tracks read beats in flight and realigns the address and valid with decoder outputs. Classifies each beat as clean, corrected or fatal, and returns registered data with a poison flag. Queues corrected beats (address plus corrected data) as scrub write-back requests, and keeps saturating error counters and a first-fatal log for CSR readout.

Parameters:
ADDR_W, 32, read-beat address width
DEC_LAT, 2, decoder latency in cycles; must equal the instantiated decoder's latency
SCRUB_DEPTH, 4, scrub FIFO entries (power of two, >=2)
CNT_W, 16, error counter width

Ports:
clock  in  1  single clock for block and decoder
reset  in  1  asynchronous, active-high reset
rd_valid  in  1  raw read beat valid from PHY side; no backpressure
rd_addr  in  ADDR_W  beat address
rd_data  in  72  raw codeword (64 data + 8 check)
dec_data  out  72  to decoder data input
dec_q  in  64  decoder corrected data
dec_err_corrected  in  1  decoder single-bit corrected flag
dec_err_detected  in  1  decoder error detected flag
dec_err_fatal  in  1  decoder uncorrectable flag
out_valid  out  1  decoded beat valid
out_addr  out  ADDR_W  decoded beat address
out_data  out  64  decoded data
out_poison  out  1  beat uncorrectable; data must not be consumed as good
scrub_valid  out  1  scrub write-back request pending
scrub_addr  out  ADDR_W  address to rewrite
scrub_data  out  64  corrected data to write
scrub_ready  in  1  scrub consumer accepts head entry
scrub_overflow  out  1  sticky: a corrected beat was dropped because the FIFO was full
corr_cnt  out  CNT_W  saturating count of corrected beats
fatal_cnt  out  CNT_W  saturating count of fatal beats
fatal_log_valid  out  1  sticky: fatal_log_addr holds the first fatal address
fatal_log_addr  out  ADDR_W  address of the first fatal beat since clear
cnt_clr  in  1  synchronous clear of counters, log and overflow flag

Behaviour:
- Reset: all outputs 0, pipeline valid bits cleared, FIFO empty. Applies mid-operation: in-flight beats are discarded and never emitted.
- dec_data = rd_data combinationally. No input register.
- Tracking pipeline: DEC_LAT-stage shift register of {rd_valid, rd_addr}. Stage DEC_LAT aligns with dec_* outputs in cycle N+DEC_LAT.
- Classification at stage DEC_LAT (valid beats only):
  - fatal = dec_err_fatal | (dec_err_detected & ~dec_err_corrected)
  - corr = dec_err_corrected & ~fatal
  - clean otherwise.
  - Decoder flags are ignored when the stage is invalid.
- Output register: out_valid, out_addr, out_data=dec_q and out_poison=fatal are registered. Total latency rd_valid -> out_valid is DEC_LAT+1 = 3 cycles. Back-to-back beats are supported at one per cycle, with no bubbles. out_poison is 0 whenever out_valid is 0.
- Scrub FIFO:
  - Push {addr, dec_q} on a corr beat. This happens in the same cycle the output register loads, so the entry is visible on scrub_valid one cycle later.
  - Pop when scrub_valid & scrub_ready.
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - If full with no pop, the entry is dropped and scrub_overflow is set (sticky).
  - scrub_valid = ~empty. scrub_addr/scrub_data reflect the head entry and hold stable while scrub_valid & ~scrub_ready.
  - FIFO pointers wrap modulo SCRUB_DEPTH. Full/empty are distinguished by an extra pointer bit.
- Counters:
  - corr_cnt increments on corr beats; fatal_cnt increments on fatal beats.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - A dropped scrub entry still counts.
- Fatal log: on the first fatal beat while fatal_log_valid=0, capture the address and set fatal_log_valid. Later fatal beats do not overwrite it.
- cnt_clr: zeroes corr_cnt, fatal_cnt, fatal_log_valid, fatal_log_addr and scrub_overflow next cycle. Clear dominates a same-cycle event: that event is neither counted nor logged. cnt_clr does not affect the FIFO or the datapath.

Test Plan:
- Clean stream: rd_valid=1 for 8 cycles, addr 0x100..0x107, no errors -> out_valid 3 cycles later for 8 consecutive cycles, same order, poison=0, counters 0, scrub_valid never set.
- Single corrected beat: addr 0x40 with one flipped data bit -> out_data equals original, poison=0, corr_cnt=1; scrub_valid rises 1 cycle after out_valid with scrub_addr=0x40 and corrected data; held until scrub_ready, then FIFO empty.
- Double-bit beat at 0x80 then another at 0x90 -> out_poison=1 for both, fatal_cnt=2, fatal_log_addr=0x80, fatal_log_valid=1, no scrub entry.
- scrub_ready=0 with 5 corrected beats (DEPTH 4) -> 4 entries retained in order, scrub_overflow=1, corr_cnt=5. Push to a full FIFO in a pop cycle is accepted with no overflow.
- CNT_W=4 with 20 corrected beats -> corr_cnt holds at 15. Assert cnt_clr in the same cycle as a corrected event -> counter 0 next cycle, event not counted.
- Assert reset with 2 beats in flight and 3 FIFO entries -> all outputs 0 at once. After release, no stale out_valid or scrub_valid; a new beat completes with 3-cycle latency.
